seg_scan_display: RTL and testbench

- Time-multiplexed 8-digit seven-segment driver.
- Sits downstream of the CPU core's display-select logic: consumes the 32-bit word chosen for display and produces the anode strobe (seg_an) and segment/dot pattern (seg) for the board's 8-digit common-anode display.
- Latches the word once per frame to prevent tearing.
- Optional leading-zero blanking and per-digit decimal points.

---
 rtl/seg_scan_display.sv | 118 +++++++++++
 tb/tb_seg_scan_display.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Ports: clk/reset (async, active-high); data[31:0] hex word, nibble k -> digit k (digit 0 rightmost);
//   dp[7:0] decimal points; blank_lz enables leading-zero blanking; seg_an[7:0] anodes (active low);
//   seg[7:0] {dp,g,f,e,d,c,b,a} (active low); frame_start pulses for one cycle when the shadow word reloads.
// Latency: anode/segment outputs are registered and follow digit_idx by one cycle.
// The display word is sampled only once per frame, at the 7->0 wrap, so a frame never shows a mix of two words.
module seg_scan_display #(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        blank_lz,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_digit_idx;
  logic [31:0]      r_shadow_data;
  logic [7:0]       r_shadow_dp;
  logic             r_shadow_blank;
  logic [7:0]       r_seg_an;
  logic [7:0]       r_seg;
  logic             r_frame_start;

  logic       w_tick;
  logic       w_wrap;
  logic [3:0] w_nibble;
  logic [6:0] w_glyph;
  logic [2:0] w_msd;
  logic       w_blank;
  logic [7:0] w_seg_next;
  logic [7:0] w_an_next;

  assign w_tick = (r_div_cnt == DIV_MAX);
  // Last digit of the frame is about to hand over to digit 0: reload point.
  assign w_wrap = w_tick && (r_digit_idx == LAST_DIGIT);

  assign w_nibble = r_shadow_data[{r_digit_idx, 2'b00} +: 4];

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    w_glyph = 7'h7F;
    case (w_nibble)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 always shows.
  always_comb begin
    w_msd = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_shadow_data[4*k +: 4] != 4'h0) begin
        w_msd = 3'(k);
      end
    end
  end

  assign w_blank    = r_shadow_blank && (r_digit_idx > w_msd);
  // Blanked digits drop the decimal point as well; the anode keeps scanning.
  assign w_seg_next = w_blank ? 8'hFF : {~r_shadow_dp[r_digit_idx], w_glyph};
  assign w_an_next  = ~(8'b1 << r_digit_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt      <= '0;
      r_digit_idx    <= 3'd0;
      r_shadow_data  <= 32'h0;
      r_shadow_dp    <= 8'h0;
      r_shadow_blank <= 1'b0;
      r_seg_an       <= 8'hFF;
      r_seg          <= 8'hFF;
      r_frame_start  <= 1'b0;
    end else begin
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_frame_start <= w_wrap;
      if (w_tick) begin
        r_digit_idx <= (r_digit_idx == LAST_DIGIT) ? 3'd0 : r_digit_idx + 3'd1;
      end
      if (w_wrap) begin
        r_shadow_data  <= data;
        r_shadow_dp    <= dp;
        r_shadow_blank <= blank_lz;
      end
      r_seg_an <= w_an_next;
      r_seg    <= w_seg_next;
    end
  end

  assign seg_an      = r_seg_an;
  assign seg         = r_seg;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4: walks several frames,
// changing inputs mid-frame, and checks anode/segment/frame_start per digit.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        blank_lz;
  logic [7:0]  seg_an;
  logic [7:0]  seg;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] arr8_t [8];

  seg_scan_display #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .dp          (dp),
    .blank_lz    (blank_lz),
    .seg_an      (seg_an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at the first negedge after digit k became visible; leaves at the
  // first negedge of the following digit.
  task automatic show_digit(input int k, input logic [7:0] exp_seg);
    logic [7:0] one;
    logic [7:0] exp_an;
    one    = 8'b1;
    exp_an = ~(one << k);
    chk($sformatf("an_d%0d_first", k), seg_an, exp_an);
    chk($sformatf("seg_d%0d_first", k), seg, exp_seg);
    repeat (3) @(negedge clk);
    chk($sformatf("an_d%0d_last", k), seg_an, exp_an);
    chk($sformatf("seg_d%0d_last", k), seg, exp_seg);
    chk($sformatf("fs_d%0d", k), {7'b0, frame_start}, {7'b0, (k == 7)});
    @(negedge clk);
  endtask

  task automatic show_range(input int lo, input int hi, input arr8_t exp);
    for (int k = lo; k <= hi; k++) show_digit(k, exp[k]);
  endtask

  arr8_t f_c0, f_hex, f_f9, f_a4, f_lz, f_zero, f_dp, f_dpblank;

  initial begin
    f_c0     = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    f_hex    = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    f_f9     = '{8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9};
    f_a4     = '{8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4};
    f_lz     = '{8'hC0, 8'h88, 8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    f_zero   = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    f_dp     = '{8'h00, 8'hF8, 8'h02, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    f_dpblank = '{8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    reset    = 1'b1;
    data     = 32'h0;
    dp       = 8'h0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_fs", {7'b0, frame_start}, 8'h00);

    reset = 1'b0;
    #1;
    chk("post_rst_first_an", seg_an, 8'hFF);
    chk("post_rst_first_seg", seg, 8'hFF);
    @(negedge clk);

    // Frame 0: shadow is zero; new word arrives mid-frame.
    show_range(0, 3, f_c0);
    data = 32'h89ABCDEF;
    show_range(4, 7, f_c0);

    // Frame 1: 89ABCDEF.
    show_range(0, 3, f_hex);
    data = 32'h11111111;
    show_range(4, 7, f_hex);

    // Frame 2: change while digit 3 is lit must not tear the frame.
    show_range(0, 2, f_f9);
    data = 32'h22222222;
    show_range(3, 7, f_f9);

    // Frame 3.
    show_range(0, 3, f_a4);
    blank_lz = 1'b1;
    data     = 32'h000003A0;
    show_range(4, 7, f_a4);

    // Frame 4: leading-zero blanking.
    show_range(0, 3, f_lz);
    data = 32'h0;
    show_range(4, 7, f_lz);

    // Frame 5: zero word keeps digit 0.
    show_range(0, 3, f_zero);
    blank_lz = 1'b0;
    dp       = 8'b0000_0101;
    data     = 32'h12345678;
    show_range(4, 7, f_zero);

    // Frame 6: decimal points.
    show_range(0, 3, f_dp);
    blank_lz = 1'b1;
    data     = 32'h5;
    show_range(4, 7, f_dp);

    // Frame 7: dp on a blanked digit is suppressed.
    show_range(0, 7, f_dpblank);

    // Frame 8: async reset while digit 5 is lit.
    show_range(0, 4, f_dpblank);
    chk("pre_arst_an", seg_an, 8'hDF);
    chk("pre_arst_seg", seg, 8'hFF);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_an_immediate", seg_an, 8'hFF);
    chk("arst_seg_immediate", seg, 8'hFF);
    chk("arst_fs_immediate", {7'b0, frame_start}, 8'h00);
    @(negedge clk);
    chk("arst_an_held", seg_an, 8'hFF);
    reset = 1'b0;
    #1;
    chk("arst_release_an", seg_an, 8'hFF);
    @(negedge clk);

    // Restart at digit 0 with a cleared shadow (blanking off, no dp).
    show_range(0, 7, f_c0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
